// File: rtl/led_pkg.sv
// Shared types and constants for the LED bin allocator and its helpers.
package led_pkg;

  // Width of one packed 8:8:8 colour word as consumed by the strip driver.
  localparam int RGB_W = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  // Allocator sequencing: capture, accumulate, divide, fix rounding, publish.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUM  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    PUB  = 3'd4
  } alloc_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per clock.
// A start accepted while idle yields a done pulse exactly N_W cycles later,
// with the quotient held stable until the next start.
module seq_divider #(
  parameter int N_W = 22,
  parameter int D_W = 20,
  parameter int Q_W = 6
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [N_W-1:0] i_dividend,
  input  logic [D_W-1:0] i_divisor,
  output logic           o_busy,
  output logic           o_done,
  output logic [Q_W-1:0] o_quotient
);

  localparam int C_W = $clog2(N_W + 1);

  logic [D_W-1:0] r_rem;
  logic [D_W-1:0] r_div;
  logic [N_W-1:0] r_quo;
  logic [C_W-1:0] r_cnt;
  logic           r_done;

  logic           w_load;
  logic [D_W-1:0] w_rem_src;
  logic [D_W-1:0] w_div_src;
  logic [N_W-1:0] w_quo_src;
  logic [D_W:0]   w_shift;
  logic [D_W-1:0] w_rem_nxt;
  logic [N_W-1:0] w_quo_nxt;

  // One restoring step; on a fresh start the step works straight from the
  // inputs so the first quotient bit costs no extra load cycle.
  always_comb begin
    w_load    = i_start && !o_busy;
    w_rem_src = w_load ? '0 : r_rem;
    w_quo_src = w_load ? i_dividend : r_quo;
    w_div_src = w_load ? i_divisor : r_div;
    w_shift   = {w_rem_src, w_quo_src[N_W-1]};
    w_rem_nxt = w_shift[D_W-1:0];
    w_quo_nxt = {w_quo_src[N_W-2:0], 1'b0};
    if (w_shift >= {1'b0, w_div_src}) begin
      w_rem_nxt = D_W'(w_shift - {1'b0, w_div_src});
      w_quo_nxt = {w_quo_src[N_W-2:0], 1'b1};
    end
  end

  // Iteration registers: the shifting quotient, partial remainder and step count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_div <= i_divisor;
        r_cnt <= C_W'(N_W - 1);
      end else if (o_busy) begin
        r_rem  <= w_rem_nxt;
        r_quo  <= w_quo_nxt;
        r_cnt  <= r_cnt - 1'b1;
        r_done <= (r_cnt == C_W'(1));
      end
    end
  end

  assign o_busy     = (r_cnt != '0);
  assign o_done     = r_done;
  assign o_quotient = r_quo[Q_W-1:0];

endmodule

// File: rtl/led_bin_allocator.sv
// Splits the strip's LEDs among frequency bins in proportion to amplitude,
// hands the loudest bin the rounding leftovers, and publishes the whole frame
// to the WS2801 driver in a single cycle while the driver reports done.
module led_bin_allocator
  import led_pkg::*;
#(
  parameter  int LEDS    = 50,
  parameter  int BIN_QTY = 12,
  parameter  int AMP_W   = 16,
  localparam int CNT_W   = $clog2(LEDS + 1),
  localparam int SUM_W   = AMP_W + $clog2(BIN_QTY),
  localparam int PROD_W  = AMP_W + CNT_W
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [BIN_QTY-1:0][AMP_W-1:0]   i_amp,
  input  rgb_t [BIN_QTY-1:0]              i_rgb_in,
  input  logic                            i_amp_valid,
  output logic                            o_ready,
  output logic                            o_overrun,
  input  logic                            i_drv_done,
  output rgb_t [BIN_QTY-1:0]              o_rgb,
  output logic [BIN_QTY-1:0][CNT_W-1:0]   o_led_counts,
  output logic                            o_start
);

  typedef rgb_t [BIN_QTY-1:0] bin_rgb_t;

  localparam int                IDX_W    = $clog2(BIN_QTY);
  localparam logic [CNT_W-1:0]  LEDS_C   = CNT_W'(LEDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BIN_QTY - 1);

  alloc_state_e                  r_state;
  alloc_state_e                  w_next_state;

  logic [BIN_QTY-1:0][AMP_W-1:0] r_amp;
  bin_rgb_t                      r_rgb_sh;
  logic [BIN_QTY-1:0][CNT_W-1:0] r_cnt_sh;
  logic [IDX_W-1:0]              r_idx;
  logic [IDX_W-1:0]              r_maxidx;
  logic [AMP_W-1:0]              r_max;
  logic [SUM_W-1:0]              r_sum;
  logic [CNT_W-1:0]              r_total;
  bin_rgb_t                      r_rgb;
  logic [BIN_QTY-1:0][CNT_W-1:0] r_led_counts;
  logic                          r_pub;
  logic                          r_start;
  logic                          r_overrun;

  logic                          w_capture;
  logic                          w_publish;
  logic                          w_last_bin;
  logic [AMP_W-1:0]              w_amp_cur;
  logic [SUM_W-1:0]              w_sum_next;
  logic                          w_div_start;
  logic [IDX_W-1:0]              w_div_idx;
  logic [AMP_W-1:0]              w_div_amp;
  logic [PROD_W-1:0]             w_dividend;
  logic [SUM_W-1:0]              w_divisor;
  logic                          w_div_busy;
  logic                          w_div_done;
  logic [CNT_W-1:0]              w_quotient;

  // Per-bin datapath taps: current bin for summing, next bin to feed the divider.
  always_comb begin
    w_amp_cur  = r_amp[r_idx];
    w_sum_next = r_sum + SUM_W'(w_amp_cur);
    w_last_bin = (r_idx == LAST_IDX);
    w_div_amp  = r_amp[w_div_idx];
    w_dividend = PROD_W'(w_div_amp) * PROD_W'(LEDS);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic plus the strobes that steer the datapath and divider.
  // The first division is launched from the last SUM cycle using the
  // not-yet-registered total, so each bin costs exactly one divider pass.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_publish    = 1'b0;
    w_div_start  = 1'b0;
    w_div_idx    = '0;
    w_divisor    = r_sum;
    case (r_state)
      IDLE: begin
        if (i_amp_valid) begin
          w_capture    = 1'b1;
          w_next_state = SUM;
        end
      end
      SUM: begin
        if (w_last_bin) begin
          if (w_sum_next == '0) begin
            w_next_state = PUB;
          end else begin
            w_next_state = DIV;
            w_div_start  = !w_div_busy;
            w_divisor    = w_sum_next;
          end
        end
      end
      DIV: begin
        if (w_div_done) begin
          if (w_last_bin) begin
            w_next_state = FIX;
          end else begin
            w_div_start = !w_div_busy;
            w_div_idx   = r_idx + 1'b1;
          end
        end
      end
      FIX: begin
        w_next_state = PUB;
      end
      PUB: begin
        if (i_drv_done) begin
          w_publish    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Shadow frame, accumulator, loudest-bin tracker, per-bin counts and the
  // driver-facing registers, which only move on the publish cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_amp        <= '0;
      r_rgb_sh     <= '0;
      r_cnt_sh     <= '0;
      r_idx        <= '0;
      r_maxidx     <= '0;
      r_max        <= '0;
      r_sum        <= '0;
      r_total      <= '0;
      r_rgb        <= '0;
      r_led_counts <= '0;
      r_pub        <= 1'b0;
      r_start      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= i_amp_valid && (r_state != IDLE);
      r_pub     <= w_publish;
      r_start   <= r_pub;
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_amp    <= i_amp;
            r_rgb_sh <= i_rgb_in;
            r_cnt_sh <= '0;
            r_idx    <= '0;
            r_maxidx <= '0;
            r_max    <= '0;
            r_sum    <= '0;
            r_total  <= '0;
          end
        end
        SUM: begin
          r_sum <= w_sum_next;
          if (w_amp_cur > r_max) begin
            r_max    <= w_amp_cur;
            r_maxidx <= r_idx;
          end
          if (w_last_bin) begin
            r_idx <= '0;
            if (w_sum_next == '0) begin
              r_cnt_sh <= '0;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DIV: begin
          if (w_div_done) begin
            r_cnt_sh[r_idx] <= w_quotient;
            r_total         <= r_total + w_quotient;
            r_idx           <= r_idx + 1'b1;
          end
        end
        FIX: begin
          r_cnt_sh[r_maxidx] <= r_cnt_sh[r_maxidx] + (LEDS_C - r_total);
        end
        PUB: begin
          if (w_publish) begin
            r_rgb        <= r_rgb_sh;
            r_led_counts <= r_cnt_sh;
          end
        end
        default: begin
        end
      endcase
    end
  end

  seq_divider #(
    .N_W (PROD_W),
    .D_W (SUM_W),
    .Q_W (CNT_W)
  ) u_divider (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  assign o_ready      = (r_state == IDLE);
  assign o_overrun    = r_overrun;
  assign o_rgb        = r_rgb;
  assign o_led_counts = r_led_counts;
  assign o_start      = r_start;

endmodule

// File: tb/tb_led_bin_allocator.sv
// Directed bench for led_bin_allocator: hand-computed LED splits, latency,
// overrun, driver back-pressure and mid-frame reset.
module tb_led_bin_allocator;

  localparam int LEDS     = 50;
  localparam int BIN_QTY  = 12;
  localparam int AMP_W    = 16;
  localparam int CNT_W    = 6;
  localparam int RGB_W    = 24;
  localparam int LAT_FULL = 1 + 12 + 12 * 22 + 1 + 1;
  localparam int LAT_ZERO = 1 + 12 + 1;

  typedef logic [BIN_QTY-1:0][AMP_W-1:0] ampVec_t;
  typedef logic [BIN_QTY-1:0][RGB_W-1:0] rgbVec_t;
  typedef logic [BIN_QTY-1:0][CNT_W-1:0] cntVec_t;
  typedef logic [287:0]                  chk_t;

  logic    clock = 1'b0;
  logic    resetN;
  ampVec_t amp;
  rgbVec_t rgbIn;
  logic    ampValid;
  logic    drvDone;
  logic    ready;
  logic    overrun;
  rgbVec_t rgbOut;
  cntVec_t ledCounts;
  logic    startPulse;

  int checksTotal  = 0;
  int checksPassed = 0;

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  led_bin_allocator #(
    .LEDS    (LEDS),
    .BIN_QTY (BIN_QTY),
    .AMP_W   (AMP_W)
  ) dut (
    .i_clk        (clock),
    .i_rst_n      (resetN),
    .i_amp        (amp),
    .i_rgb_in     (rgbIn),
    .i_amp_valid  (ampValid),
    .o_ready      (ready),
    .o_overrun    (overrun),
    .i_drv_done   (drvDone),
    .o_rgb        (rgbOut),
    .o_led_counts (ledCounts),
    .o_start      (startPulse)
  );

  task automatic checkOutput(input string tag, input chk_t observed, input chk_t expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic rgbVec_t makeRgb(input int tag);
    rgbVec_t r;
    for (int i = 0; i < BIN_QTY; i++) begin
      r[i] = {8'(tag), 8'(i), 8'(tag + i)};
    end
    return r;
  endfunction

  function automatic int sumCounts(input cntVec_t c);
    int s = 0;
    for (int i = 0; i < BIN_QTY; i++) begin
      s += int'(c[i]);
    end
    return s;
  endfunction

  task automatic applyStimulus(input ampVec_t a, input rgbVec_t c);
    @(negedge clock);
    amp      = a;
    rgbIn    = c;
    ampValid = 1'b1;
    @(posedge clock);
    #1;
    ampValid = 1'b0;
  endtask

  // Runs one frame and checks latency, stability before publish, the
  // published counts/colours and the single start pulse.
  task automatic runFrame(input string name, input ampVec_t a, input int tag,
                          input cntVec_t expCnt, input int expLat,
                          input int holdEdge, input int injEdge);
    cntVec_t oldCnt;
    rgbVec_t oldRgb;
    rgbVec_t expRgb;
    int      chEdge;
    int      stEdge;
    int      expUpd;
    int      expSum;
    oldCnt = ledCounts;
    oldRgb = rgbOut;
    expRgb = makeRgb(tag);
    chEdge = -1;
    stEdge = -1;
    expSum = (a == '0) ? 0 : LEDS;
    expUpd = (holdEdge > 0) ? holdEdge + 2 : expLat;
    applyStimulus(a, expRgb);
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clock);
      #1;
      if (chEdge < 0 && (ledCounts != oldCnt || rgbOut != oldRgb)) chEdge = n;
      if (n == holdEdge) drvDone = 1'b1;
      if (injEdge > 0) begin
        if (n == injEdge) begin
          amp      = '1;
          ampValid = 1'b1;
        end
        if (n == injEdge + 1) begin
          checkOutput({name, " overrun_pulse"}, chk_t'(overrun), chk_t'(1'b1));
          ampValid = 1'b0;
        end
        if (n == injEdge + 2) checkOutput({name, " overrun_clear"}, chk_t'(overrun), chk_t'(1'b0));
      end
      if (startPulse) begin
        stEdge = n;
        break;
      end
    end
    if (stEdge < 0) begin
      checkOutput({name, " start_timeout"}, chk_t'(1'b0), chk_t'(1'b1));
    end else begin
      checkOutput({name, " update_latency"}, chk_t'(chEdge + 1), chk_t'(expUpd));
      checkOutput({name, " start_after_update"}, chk_t'(stEdge), chk_t'(chEdge + 1));
      checkOutput({name, " counts"}, chk_t'(ledCounts), chk_t'(expCnt));
      checkOutput({name, " rgb"}, chk_t'(rgbOut), chk_t'(expRgb));
      checkOutput({name, " count_sum"}, chk_t'(sumCounts(ledCounts)), chk_t'(expSum));
      @(posedge clock);
      #1;
      checkOutput({name, " start_single"}, chk_t'(startPulse), chk_t'(1'b0));
    end
    drvDone = 1'b1;
  endtask

  // Directed sequence of frames with hand-computed LED splits.
  initial begin
    ampVec_t a;
    cntVec_t e;
    resetN   = 1'b0;
    amp      = '0;
    rgbIn    = '0;
    ampValid = 1'b0;
    drvDone  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset counts", chk_t'(ledCounts), chk_t'(0));
    checkOutput("reset rgb", chk_t'(rgbOut), chk_t'(0));
    checkOutput("reset ready", chk_t'(ready), chk_t'(1'b1));
    checkOutput("reset start", chk_t'(startPulse), chk_t'(1'b0));
    checkOutput("reset overrun", chk_t'(overrun), chk_t'(1'b0));
    @(negedge clock);
    resetN = 1'b1;

    // All 100: 5000/1200 = 4 each, 48 total, deficit 2 to bin 0 by tie rule.
    for (int i = 0; i < BIN_QTY; i++) begin
      a[i] = 16'd100;
      e[i] = 6'd4;
    end
    e[0] = 6'd6;
    runFrame("equal", a, 1, e, LAT_FULL, 0, 0);

    // Single loud bin takes the whole strip.
    a = '0; a[3] = 16'd500;
    e = '0; e[3] = 6'd50;
    runFrame("single", a, 2, e, LAT_FULL, 0, 0);

    // Silent frame skips division entirely.
    a = '0;
    e = '0;
    runFrame("silent", a, 3, e, LAT_ZERO, 0, 0);

    // 50000/1011 = 49, others 50/1011 = 0, deficit 1 to bin 0.
    for (int i = 0; i < BIN_QTY; i++) a[i] = 16'd1;
    a[0] = 16'd1000;
    e = '0; e[0] = 6'd50;
    runFrame("dominant", a, 4, e, LAT_FULL, 0, 0);

    // Ramp i*10, sum 660: floor(500*i/660), total 45, deficit 5 to bin 11.
    // A second frame strobed mid-division must be dropped.
    for (int i = 0; i < BIN_QTY; i++) a[i] = AMP_W'(i * 10);
    e = {6'd13, 6'd7, 6'd6, 6'd6, 6'd5, 6'd4, 6'd3, 6'd3, 6'd2, 6'd1, 6'd0, 6'd0};
    runFrame("ramp_overrun", a, 5, e, LAT_FULL, 0, 50);

    // Driver busy for 100 cycles in PUB; a strobe on the exit cycle is dropped.
    a = '0; a[5] = 16'd7; a[9] = 16'd3;
    e = '0; e[5] = 6'd35; e[9] = 6'd15;
    drvDone = 1'b0;
    runFrame("held", a, 6, e, 0, 377, 377);
    checkOutput("held ready_after_exit_strobe", chk_t'(ready), chk_t'(1'b1));

    // Reset in the middle of a division, then a clean frame.
    for (int i = 0; i < BIN_QTY; i++) a[i] = 16'd100;
    applyStimulus(a, makeRgb(7));
    repeat (100) @(posedge clock);
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("midreset counts", chk_t'(ledCounts), chk_t'(0));
    checkOutput("midreset rgb", chk_t'(rgbOut), chk_t'(0));
    checkOutput("midreset ready", chk_t'(ready), chk_t'(1'b1));
    @(negedge clock);
    resetN = 1'b1;
    a = '0; a[0] = 16'd2; a[11] = 16'd1;
    e = '0; e[0] = 6'd34; e[11] = 6'd16;
    runFrame("after_reset", a, 8, e, LAT_FULL, 0, 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
